// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer in front of a single MemHier port.
// Round-robin grant, one-cycle request pulse, completion wait with optional timeout, one-cycle done strobe.
module mem_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rd_data,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_wr_ctrl,
  input  logic [2:0]  d_rd_ctrl,
  input  logic [31:0] d_wr_data,
  output logic [31:0] d_rd_data,
  output logic        d_done,
  output logic        err,
  output logic        mem_read_req,
  output logic        mem_write_req,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_wr_ctrl,
  output logic [2:0]  mem_rd_ctrl,
  output logic [31:0] mem_wr_data,
  input  logic        mem_rd_data_valid,
  input  logic        mem_wr_ready,
  input  logic [31:0] mem_rd_data
);

  localparam logic [2:0] RD_LW = 3'b011;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t        state;
  logic          last_d;   // last grant went to D; also names the owner of the access in flight
  logic          op_wr;
  logic [CW-1:0] to_cnt;

  logic          grant_d;
  logic          hit;
  logic          expired;
  logic          fin;
  logic          fin_err;
  logic [31:0]   fin_data;

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    fin     = 1'b0;
    fin_err = 1'b0;
    grant_d = d_req && (!i_req || !last_d);
    hit     = op_wr ? mem_wr_ready : mem_rd_data_valid;
    expired = (TIMEOUT != 0) && (to_cnt == TO_LAST);
    case (state)
      S_ISSUE: fin = hit;
      S_WAIT: begin
        fin     = hit || expired;
        fin_err = !hit && expired;
      end
      default: ;
    endcase
    fin_data = (op_wr || !hit) ? '0 : mem_rd_data;
  end

  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      last_d        <= 1'b1;
      op_wr         <= 1'b0;
      to_cnt        <= '0;
      i_rd_data     <= '0;
      i_done        <= 1'b0;
      d_rd_data     <= '0;
      d_done        <= 1'b0;
      err           <= 1'b0;
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      mem_addr      <= '0;
      mem_wr_ctrl   <= '0;
      mem_rd_ctrl   <= '0;
      mem_wr_data   <= '0;
    end else begin
      mem_read_req  <= 1'b0;
      mem_write_req <= 1'b0;
      i_done        <= 1'b0;
      d_done        <= 1'b0;
      err           <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_req || d_req) begin
            state  <= S_ISSUE;
            last_d <= grant_d;
            if (grant_d) begin
              op_wr         <= d_we;
              mem_read_req  <= !d_we;
              mem_write_req <= d_we;
              mem_addr      <= d_addr;
              mem_wr_ctrl   <= d_we ? d_wr_ctrl : 2'b00;
              mem_rd_ctrl   <= d_we ? 3'b000 : d_rd_ctrl;
              mem_wr_data   <= d_we ? d_wr_data : '0;
            end else begin
              op_wr        <= 1'b0;
              mem_read_req <= 1'b1;
              mem_addr     <= i_addr;
              mem_wr_ctrl  <= 2'b00;
              mem_rd_ctrl  <= RD_LW;
              mem_wr_data  <= '0;
            end
          end
        end

        S_ISSUE: begin
          to_cnt <= '0;
          if (!fin) state <= S_WAIT;
        end

        S_WAIT: begin
          if (!fin) to_cnt <= to_cnt + 1'b1;
        end

        S_DONE: begin
          state     <= S_IDLE;
          i_rd_data <= '0;
          d_rd_data <= '0;
        end

        default: state <= S_IDLE;
      endcase

      // Completion from ISSUE or WAIT: strobe the owner exactly once.
      if (fin) begin
        state <= S_DONE;
        err   <= fin_err;
        if (last_d) begin
          d_done    <= 1'b1;
          d_rd_data <= fin_data;
        end else begin
          i_done    <= 1'b1;
          i_rd_data <= fin_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a MemHier responder model plus request/done scoreboards
// filled by the stimulus and drained by a negedge monitor.
module tb_mem_arbiter;

  localparam int         TO = 4;
  localparam logic [2:0] LW = 3'b011;
  localparam logic [1:0] SW = 2'b11;

  logic        clk;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wr_data;
  logic [1:0]  d_wr_ctrl;
  logic [2:0]  d_rd_ctrl;
  logic [31:0] i_rd_data, d_rd_data;
  logic        i_done, d_done, err;
  logic        mem_read_req, mem_write_req;
  logic [31:0] mem_addr, mem_wr_data;
  logic [1:0]  mem_wr_ctrl;
  logic [2:0]  mem_rd_ctrl;
  logic        mem_rd_data_valid, mem_wr_ready;
  logic [31:0] mem_rd_data;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_ctrl(d_wr_ctrl),
    .d_rd_ctrl(d_rd_ctrl), .d_wr_data(d_wr_data), .d_rd_data(d_rd_data),
    .d_done(d_done), .err(err),
    .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
    .mem_addr(mem_addr), .mem_wr_ctrl(mem_wr_ctrl), .mem_rd_ctrl(mem_rd_ctrl),
    .mem_wr_data(mem_wr_data), .mem_rd_data_valid(mem_rd_data_valid),
    .mem_wr_ready(mem_wr_ready), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  wc;
    logic [2:0]  rc;
    logic [31:0] wd;
  } req_exp_t;

  typedef struct {
    logic        d;
    logic [31:0] data;
    logic        err;
  } done_exp_t;

  req_exp_t  req_q[$];
  done_exp_t done_q[$];

  int n_checks = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, last_pulse_cyc = -100, last_done_cyc = -100;
  int pulse_total = 0, done_total = 0, exp_pulse_n = 0, exp_done_n = 0;

  // MemHier model: responds resp_delay cycles after the pulse (0 = same cycle).
  logic [31:0] mem_model [16] = '{1: 32'h1, 2: 32'h22, 3: 32'h33, default: 32'h0};
  int          resp_delay = 3;
  bit          resp_on = 1'b1;
  logic        stray_wr = 1'b0;
  logic        resp_rd_valid = 1'b0, resp_wr_ready = 1'b0;
  logic [31:0] resp_rd_data = '0;
  bit          pend = 1'b0, pend_rd = 1'b0, pend_wr = 1'b0;
  int          pend_cnt = 0;
  logic [3:0]  pend_idx = '0;
  logic        same_cycle;

  assign same_cycle        = resp_on && (resp_delay == 0);
  assign mem_rd_data_valid = resp_rd_valid | (same_cycle & mem_read_req);
  assign mem_wr_ready      = resp_wr_ready | stray_wr | (same_cycle & mem_write_req);
  assign mem_rd_data       = (same_cycle && mem_read_req) ? mem_model[mem_addr[3:0]] : resp_rd_data;

  always @(posedge clk) begin
    cyc           <= cyc + 1;
    resp_rd_valid <= 1'b0;
    resp_wr_ready <= 1'b0;
    if (mem_read_req || mem_write_req) begin
      if (mem_write_req) mem_model[mem_addr[3:0]] <= mem_wr_data;
      if (resp_on && resp_delay == 1) begin
        resp_rd_valid <= mem_read_req;
        resp_wr_ready <= mem_write_req;
        resp_rd_data  <= mem_model[mem_addr[3:0]];
      end else if (resp_on && resp_delay > 1) begin
        pend     <= 1'b1;
        pend_rd  <= mem_read_req;
        pend_wr  <= mem_write_req;
        pend_cnt <= resp_delay - 2;
        pend_idx <= mem_addr[3:0];
      end
    end else if (pend) begin
      if (pend_cnt == 0) begin
        pend          <= 1'b0;
        resp_rd_valid <= pend_rd;
        resp_wr_ready <= pend_wr;
        resp_rd_data  <= mem_model[pend_idx];
      end else begin
        pend_cnt <= pend_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Monitor: every request pulse and every done strobe is matched against the scoreboards.
  always @(negedge clk) begin
    if (rst) begin
      check("err_without_done", {31'b0, err & ~(i_done | d_done)}, 32'd0);
      if (mem_read_req || mem_write_req) begin
        check("req_one_hot", {31'b0, mem_read_req & mem_write_req}, 32'd0);
        check("pulse_gap_ge3", {31'b0, (cyc - last_pulse_cyc) >= 3}, 32'd1);
        check("pulse_expected", {31'b0, req_q.size() != 0}, 32'd1);
        if (req_q.size() != 0) begin
          req_exp_t e;
          e = req_q.pop_front();
          check("req_is_write", {31'b0, mem_write_req}, {31'b0, e.wr});
          check("req_addr", mem_addr, e.addr);
          check("req_wr_ctrl", {30'b0, mem_wr_ctrl}, {30'b0, e.wc});
          check("req_rd_ctrl", {29'b0, mem_rd_ctrl}, {29'b0, e.rc});
          if (e.wr) check("req_wr_data", mem_wr_data, e.wd);
        end
        last_pulse_cyc = cyc;
        pulse_total++;
      end
      if (i_done || d_done) begin
        check("done_one_hot", {31'b0, i_done & d_done}, 32'd0);
        check("done_expected", {31'b0, done_q.size() != 0}, 32'd1);
        if (done_q.size() != 0) begin
          done_exp_t e;
          e = done_q.pop_front();
          check("done_owner_d", {31'b0, d_done}, {31'b0, e.d});
          check("done_rd_data", d_done ? d_rd_data : i_rd_data, e.data);
          check("done_err", {31'b0, err}, {31'b0, e.err});
        end
        last_done_cyc = cyc;
        done_total++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_total < target && k < budget) begin
      tick();
      k++;
    end
    check(tag, {31'b0, done_total >= target}, 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {20'b0, mem_read_req, mem_write_req, i_done, d_done, err,
                              mem_wr_ctrl, mem_rd_ctrl, 2'b0}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wr_data"}, mem_wr_data, 32'd0);
    check({tag, "_i_rd_data"}, i_rd_data, 32'd0);
    check({tag, "_d_rd_data"}, d_rd_data, 32'd0);
  endtask

  task automatic expect_req(input logic wr, input logic [31:0] addr, input logic [1:0] wc,
                            input logic [2:0] rc, input logic [31:0] wd);
    req_q.push_back(req_exp_t'{wr, addr, wc, rc, wd});
    exp_pulse_n++;
  endtask

  task automatic expect_done(input logic d, input logic [31:0] data, input logic e);
    done_q.push_back(done_exp_t'{d, data, e});
    exp_done_n++;
  endtask

  task automatic i_read(input logic [31:0] addr, input logic [31:0] exp_data);
    expect_req(1'b0, addr, 2'b00, LW, 32'h0);
    expect_done(1'b0, exp_data, 1'b0);
    i_req  = 1'b1;
    i_addr = addr;
    wait_done(exp_done_n, 30, "i_done_seen");
    i_req = 1'b0;
  endtask

  // Loads still present store-side fields so the bench sees them masked off.
  task automatic d_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_data, input logic exp_err);
    expect_req(we, addr, we ? SW : 2'b00, we ? 3'b000 : LW, wdata);
    expect_done(1'b1, we ? 32'h0 : exp_data, exp_err);
    d_req     = 1'b1;
    d_we      = we;
    d_addr    = addr;
    d_wr_ctrl = SW;
    d_rd_ctrl = LW;
    d_wr_data = wdata;
    wait_done(exp_done_n, 30, "d_done_seen");
    d_req = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wr_ctrl = '0; d_rd_ctrl = '0; d_wr_data = '0;
    tick(2);
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Fetch read, MemHier answers 3 cycles after the pulse.
    resp_delay = 3;
    i_read(32'h1, 32'h1);
    check("i_read_latency", last_done_cyc - last_pulse_cyc, 32'd4);
    tick();

    // Store then load, plus a second pair on a fresh address.
    resp_delay = 2;
    d_access(1'b1, 32'h1, 32'h1, 32'h0, 1'b0);
    tick();
    d_access(1'b0, 32'h1, 32'hDEAD_BEEF, 32'h1, 1'b0);
    tick();
    d_access(1'b1, 32'h4, 32'hA5A5_0042, 32'h0, 1'b0);
    tick();
    d_access(1'b0, 32'h4, 32'h0, 32'hA5A5_0042, 1'b0);
    tick();

    // Both requesters held from reset: grants alternate starting with I.
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    resp_delay = 1;
    for (int k = 0; k < 2; k++) begin
      expect_req(1'b0, 32'h2, 2'b00, LW, 32'h0);
      expect_done(1'b0, 32'h22, 1'b0);
      expect_req(1'b0, 32'h3, 2'b00, LW, 32'h0);
      expect_done(1'b1, 32'h33, 1'b0);
    end
    i_req = 1'b1; i_addr = 32'h2;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3; d_rd_ctrl = LW; d_wr_ctrl = SW;
    wait_done(exp_done_n, 60, "both_done_seen");
    i_req = 1'b0;
    d_req = 1'b0;
    tick();

    // Completion in the ISSUE cycle: done one cycle after the pulse.
    resp_delay = 0;
    i_read(32'h3, 32'h33);
    check("issue_cycle_latency", last_done_cyc - last_pulse_cyc, 32'd1);
    tick();

    // MemHier silent: done with err after the 4th WAIT cycle.
    resp_on = 1'b0;
    d_access(1'b0, 32'h5, 32'h0, 32'h0, 1'b1);
    check("timeout_latency", last_done_cyc - last_pulse_cyc, 32'd5);
    tick();

    // Stray write-ready while idle, then during a read WAIT.
    resp_on    = 1'b1;
    resp_delay = 3;
    stray_wr   = 1'b1;
    tick();
    stray_wr = 1'b0;
    tick(3);
    check("stray_idle_no_done", done_total, exp_done_n);
    check("stray_idle_no_pulse", pulse_total, exp_pulse_n);
    expect_req(1'b0, 32'h1, 2'b00, LW, 32'h0);
    expect_done(1'b0, 32'h1, 1'b0);
    i_req  = 1'b1;
    i_addr = 32'h1;
    tick(2);
    stray_wr = 1'b1;
    tick();
    stray_wr = 1'b0;
    wait_done(exp_done_n, 30, "stray_wait_done_seen");
    i_req = 1'b0;
    check("stray_wait_latency", last_done_cyc - last_pulse_cyc, 32'd4);
    tick();

    // Reset mid-WAIT aborts the access with no done.
    resp_on = 1'b0;
    expect_req(1'b0, 32'h6, 2'b00, LW, 32'h0);
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h6;
    tick(3);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid_wait_reset");
    d_req = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(4);
    check("no_done_after_abort", done_total, exp_done_n);
    check("pulse_count", pulse_total, exp_pulse_n);
    check("req_q_drained", req_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer in front of `MemHier`. It shares the single memory-hierarchy port between the instruction-fetch requester (I, read-only) and the data requester (D, load/store). Each access is converted into the one-cycle `read_req`/`write_req` pulse that `MemHier` expects. The arbiter then waits for `rd_data_valid`/`wr_ready` and returns a one-cycle done strobe to the owning requester. It sits between the CPU core's fetch/LSU stages and `MemHier`.

## Interface
- `TIMEOUT`, 255: maximum cycles in WAIT before forced completion with error; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `i_req` in 1: fetch request, held until `i_done`.
- `i_addr` in 32: fetch address.
- `i_rd_data` out 32: fetch data, valid while `i_done`=1.
- `i_done` out 1: one-cycle completion strobe for I.
- `d_req` in 1: data request, held until `d_done`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data address.
- `d_wr_ctrl` in 2: store width (`SW`/`SH`/`SB`).
- `d_rd_ctrl` in 3: load width/sign (`LW`…).
- `d_wr_data` in 32: store data.
- `d_rd_data` out 32: load data, valid while `d_done`=1.
- `d_done` out 1: one-cycle completion strobe for D.
- `err` out 1: pulses with done when the access ended by timeout.
- `mem_read_req`, `mem_write_req` out 1 each: request pulses to `MemHier`.
- `mem_addr` out 32, `mem_wr_ctrl` out 2, `mem_rd_ctrl` out 3, `mem_wr_data` out 32: request fields, held stable from ISSUE through WAIT.
- `mem_rd_data_valid` in 1, `mem_wr_ready` in 1, `mem_rd_data` in 32: `MemHier` completion.

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if either request is high, select a winner and latch addr, ctrl, data, op and owner → ISSUE. If neither is high, stay in IDLE.
- Arbitration is round-robin: when both requesters are high, grant the port not granted last. After reset, `last` = D, so I wins the first tie. `last` updates at each grant.
- I accesses are reads with `mem_rd_ctrl`=`LW` and `mem_wr_ctrl`=0. D loads drive `mem_wr_ctrl`=0. D stores drive `mem_rd_ctrl`=0.
- ISSUE: exactly one of `mem_read_req`/`mem_write_req` is 1 for this one cycle → WAIT. A matching completion seen in this cycle is accepted and goes directly to DONE.
- WAIT: both mem request pulses are 0.
  - Reads complete on `mem_rd_data_valid`=1; `mem_rd_data` is latched.
  - Writes complete on `mem_wr_ready`=1.
  - The non-matching completion signal is ignored.
  - On completion → DONE.
- Timeout: the counter clears on entering WAIT and increments each WAIT cycle. When it reaches `TIMEOUT` without completion → DONE with `err`=1 and read data forced to 0.
- DONE: the owner's `*_done`=1 for one cycle, with `*_rd_data` = latched data (0 for writes) → IDLE.
- Completion inputs seen in IDLE or DONE are ignored; they are stray.
- Once latched, a transaction runs to completion even if the requester drops `req`.

## Timing
- Reset (async, `rst`=0): state IDLE, `last`=D, timeout counter 0. All outputs are 0, including `mem_*` fields, `*_rd_data`, `*_done` and `err`.
- Request high in IDLE cycle N → `mem_*_req`=1 in cycle N+1.
- Completion in cycle M (M ≥ N+1) → `*_done`=1 in cycle M+1, IDLE in cycle M+2.
- Minimum request-to-done latency is 2 cycles (completion in the ISSUE cycle). Throughput is at most one access per 3 cycles.
- A requester samples done at the end of cycle M+1 and must update `req` in M+2. IDLE samples `req` at the end of M+2, so a held `req` in M+2 is a new access.
- `rst` asserted mid-transaction aborts it: no done pulse, and `MemHier` state is outside this block's scope.

## Test plan
- I read alone:
  - `i_req`=1, `i_addr`=0x1, `MemHier` returns `rd_data_valid` 3 cycles after the pulse with `rd_data`=0x1.
  - Required: one `mem_read_req` pulse, `mem_rd_ctrl`=`LW`, `i_done`=1 with `i_rd_data`=0x1, `d_done` stays 0.
- D store then load:
  - Store `d_addr`=0x1, `SW`, data 0x1, then load `d_addr`=0x1, `LW`.
  - Required: one `mem_write_req` pulse with `mem_wr_data`=0x1, then `d_done`. Next, one `mem_read_req` pulse, then `d_done` with `d_rd_data`=0x1.
- Simultaneous requests:
  - Both `i_req` and `d_req` held continuously after reset.
  - Required: grant order I, D, I, D…; each done pulses once per access; no two mem pulses within 3 cycles.
- Completion in the ISSUE cycle:
  - `mem_rd_data_valid`=1 in the same cycle as `mem_read_req`.
  - Required: done exactly 2 cycles after the request was sampled, and no WAIT cycle.
- Timeout:
  - `TIMEOUT`=4 and `MemHier` never responds.
  - Required: `d_done`=1 and `err`=1 in the cycle after the 4th WAIT cycle, `d_rd_data`=0, then IDLE.
- Stray signals and reset:
  - `mem_wr_ready` pulses while IDLE and during a read WAIT.
  - Required: no done pulse for either.
  - Asserting `rst`=0 mid-WAIT returns all outputs to 0 immediately.
